// File: rtl/controle_soma_flt.sv
// Multi-cycle binary32 add/subtract sequencer: compare/swap, align, add, normalize and
// round-to-nearest-even, with a valid/ready handshake on both the operand and result sides.
module controle_soma_flt #(
    parameter logic [31:0] NAN_CANONICO = 32'h7FC0_0000,
    parameter int unsigned GRS          = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic        flag_invalido,
    output logic        flag_overflow,
    output logic        flag_inexato
);

    localparam int unsigned SW = 24 + GRS;

    typedef enum logic [2:0] {
        LIVRE     = 3'd0,
        COMPARA   = 3'd1,
        ALINHA    = 3'd2,
        SOMA      = 3'd3,
        NORMALIZA = 3'd4,
        ARREDONDA = 3'd5,
        PRONTO    = 3'd6
    } estado_t;

    estado_t        estado_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [31:0]    s_q;
    logic           inv_q;
    logic           ovf_q;
    logic           inx_q;

    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic           sub_q;

    logic           sx_q, sx_d;
    logic           sy_q, sy_d;
    logic [7:0]     ex_q, ex_d;
    logic [7:0]     ey_q, ey_d;
    logic [23:0]    mx_q, mx_d;
    logic [23:0]    my_q, my_d;
    logic           esp_q, esp_d;
    logic [31:0]    esp_val_q, esp_val_d;
    logic           esp_inv_q, esp_inv_d;

    logic [SW-1:0]  xa_q, xa_d;
    logic [SW-1:0]  ya_q, ya_d;
    logic [SW:0]    sum_q, sum_d;

    logic [SW-1:0]  nm_q, nm_d;
    logic [9:0]     ne_q, ne_d;
    logic           nz_q, nz_d;
    logic [31:0]    nz_val_q, nz_val_d;
    logic           nz_inx_q, nz_inx_d;

    logic [31:0]    res_d;
    logic           inv_d, ovf_d, inx_d;

    function automatic logic [4:0] conta_zeros(input logic [SW-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < int'(SW); i++) begin
            n = v[i] ? 5'(int'(SW) - 1 - i) : n;
        end
        return n;
    endfunction

    logic        sa, sb;
    logic        nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
    logic [30:0] mag_a, mag_b;
    logic        troca;

    // Operand classification, flush-to-zero, magnitude swap and special-result decision
    always_comb begin
        sa    = a_q[31];
        sb    = b_q[31] ^ sub_q;
        nan_a = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        nan_b = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        inf_a = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        inf_b = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        zer_a = (a_q[30:23] == 8'd0);
        zer_b = (b_q[30:23] == 8'd0);
        mag_a = zer_a ? 31'd0 : a_q[30:0];
        mag_b = zer_b ? 31'd0 : b_q[30:0];
        troca = (mag_b > mag_a);

        sx_d = troca ? sb : sa;
        sy_d = troca ? sa : sb;
        ex_d = troca ? mag_b[30:23] : mag_a[30:23];
        ey_d = troca ? mag_a[30:23] : mag_b[30:23];
        mx_d = troca ? {~zer_b, mag_b[22:0]} : {~zer_a, mag_a[22:0]};
        my_d = troca ? {~zer_a, mag_a[22:0]} : {~zer_b, mag_b[22:0]};

        esp_d     = 1'b1;
        esp_val_d = 32'd0;
        esp_inv_d = 1'b0;
        if (nan_a || nan_b) begin
            esp_val_d = NAN_CANONICO;
            esp_inv_d = 1'b1;
        end else if (inf_a && inf_b) begin
            if (sa != sb) begin
                esp_val_d = NAN_CANONICO;
                esp_inv_d = 1'b1;
            end else begin
                esp_val_d = {sa, 8'hFF, 23'd0};
            end
        end else if (inf_a) begin
            esp_val_d = {sa, 8'hFF, 23'd0};
        end else if (inf_b) begin
            esp_val_d = {sb, 8'hFF, 23'd0};
        end else if (zer_a && zer_b) begin
            esp_val_d = {sa & sb, 31'd0};
        end else begin
            esp_d = 1'b0;
        end
    end

    logic [7:0]    dif;
    logic [SW-1:0] y_ext, y_sh;
    logic          perdido;

    // Alignment: everything shifted past the round bit collapses into sticky
    always_comb begin
        dif     = ex_q - ey_q;
        xa_d    = {mx_q, {GRS{1'b0}}};
        y_ext   = {my_q, {GRS{1'b0}}};
        y_sh    = y_ext >> dif[4:0];
        perdido = |(y_ext & ((SW'(1) << dif[4:0]) - SW'(1)));
        if (dif >= 8'(SW)) begin
            ya_d = {{(SW-1){1'b0}}, |y_ext};
        end else begin
            ya_d = {y_sh[SW-1:1], y_sh[0] | perdido};
        end
    end

    // Magnitude add or subtract; the swap guarantees the difference is non-negative
    always_comb begin
        if (sx_q == sy_q) begin
            sum_d = {1'b0, xa_q} + {1'b0, ya_q};
        end else begin
            sum_d = {1'b0, xa_q} - {1'b0, ya_q};
        end
    end

    logic [4:0] lz;

    // Normalization and flush of results that fall below the normal range
    always_comb begin
        lz       = conta_zeros(sum_q[SW-1:0]);
        nm_d     = sum_q[SW-1:0] << lz;
        ne_d     = {2'b00, ex_q} - {5'd0, lz};
        nz_d     = 1'b0;
        nz_val_d = 32'd0;
        nz_inx_d = 1'b0;
        if (sum_q == {(SW+1){1'b0}}) begin
            nz_d = 1'b1;
        end else begin
            if (sum_q[SW]) begin
                nm_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
                ne_d = {2'b00, ex_q} + 10'd1;
            end else begin
                nm_d = sum_q[SW-1:0] << lz;
            end
            if (ne_d[9] || (ne_d == 10'd0)) begin
                nz_d     = 1'b1;
                nz_val_d = {sx_q, 31'd0};
                nz_inx_d = 1'b1;
            end else begin
                nz_d = 1'b0;
            end
        end
    end

    logic [23:0] sig;
    logic        g_b, r_b, st_b, sobe;
    logic [24:0] sig_r;
    logic [9:0]  e_r;

    // Round to nearest even and final result/flag selection
    always_comb begin
        sig   = nm_q[SW-1:GRS];
        g_b   = nm_q[GRS-1];
        r_b   = nm_q[GRS-2];
        st_b  = |nm_q[GRS-3:0];
        sobe  = g_b & (r_b | st_b | sig[0]);
        sig_r = {1'b0, sig} + {24'd0, sobe};
        e_r   = ne_q + {9'd0, sig_r[24]};
        inv_d = 1'b0;
        ovf_d = 1'b0;
        inx_d = 1'b0;
        if (esp_q) begin
            res_d = esp_val_q;
            inv_d = esp_inv_q;
        end else if (nz_q) begin
            res_d = nz_val_q;
            inx_d = nz_inx_q;
        end else if (e_r >= 10'd255) begin
            res_d = {sx_q, 8'hFF, 23'd0};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else begin
            // A cleared hidden bit means rounding carried out: fraction wraps to zero
            res_d = {sx_q, e_r[7:0], sig_r[23] ? sig_r[22:0] : 23'd0};
            inx_d = g_b | r_b | st_b;
        end
    end

    // Sequencer FSM with per-phase datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= LIVRE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= 32'd0;
            inv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            inx_q       <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            sub_q       <= 1'b0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            ex_q        <= 8'd0;
            ey_q        <= 8'd0;
            mx_q        <= 24'd0;
            my_q        <= 24'd0;
            esp_q       <= 1'b0;
            esp_val_q   <= 32'd0;
            esp_inv_q   <= 1'b0;
            xa_q        <= {SW{1'b0}};
            ya_q        <= {SW{1'b0}};
            sum_q       <= {(SW+1){1'b0}};
            nm_q        <= {SW{1'b0}};
            ne_q        <= 10'd0;
            nz_q        <= 1'b0;
            nz_val_q    <= 32'd0;
            nz_inx_q    <= 1'b0;
        end else begin
            case (estado_q)
                LIVRE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        sub_q      <= sub;
                        in_ready_q <= 1'b0;
                        estado_q   <= COMPARA;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                COMPARA: begin
                    sx_q      <= sx_d;
                    sy_q      <= sy_d;
                    ex_q      <= ex_d;
                    ey_q      <= ey_d;
                    mx_q      <= mx_d;
                    my_q      <= my_d;
                    esp_q     <= esp_d;
                    esp_val_q <= esp_val_d;
                    esp_inv_q <= esp_inv_d;
                    estado_q  <= ALINHA;
                end
                ALINHA: begin
                    xa_q     <= xa_d;
                    ya_q     <= ya_d;
                    estado_q <= SOMA;
                end
                SOMA: begin
                    sum_q    <= sum_d;
                    estado_q <= NORMALIZA;
                end
                NORMALIZA: begin
                    nm_q     <= nm_d;
                    ne_q     <= ne_d;
                    nz_q     <= nz_d;
                    nz_val_q <= nz_val_d;
                    nz_inx_q <= nz_inx_d;
                    estado_q <= ARREDONDA;
                end
                ARREDONDA: begin
                    s_q         <= res_d;
                    inv_q       <= inv_d;
                    ovf_q       <= ovf_d;
                    inx_q       <= inx_d;
                    out_valid_q <= 1'b1;
                    estado_q    <= PRONTO;
                end
                PRONTO: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        estado_q    <= LIVRE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    estado_q    <= LIVRE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign s             = s_q;
    assign flag_invalido = inv_q;
    assign flag_overflow = ovf_q;
    assign flag_inexato  = inx_q;

endmodule

// File: tb/tb_controle_soma_flt.sv
// Scoreboard bench for controle_soma_flt: exact-arithmetic reference model, directed corner
// cases, handshake/latency/reset-abort scenarios and randomized operands.
module tb_controle_soma_flt;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        flag_invalido;
    logic        flag_overflow;
    logic        flag_inexato;

    controle_soma_flt dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .sub           (sub),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .s             (s),
        .flag_invalido (flag_invalido),
        .flag_overflow (flag_overflow),
        .flag_inexato  (flag_inexato)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NAN_C = 32'h7FC0_0000;

    int          erros  = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [34:0] exp_q[$];
    int          acc_cyc[$];
    int          pend_acc = -1;
    logic        prev_ov  = 1'b0;
    logic [34:0] prev_sf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            erros++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nome, got, req, cyc);
        end
    endtask

    // Exact reference: true sum as a wide integer, then normalize/round by value.
    function automatic logic [34:0] ref_model(input logic [31:0] x_in, input logic [31:0] y_in,
                                              input logic op_sub);
        logic        sa, sb, sx, sy;
        int          ea, eb, ex, ey, d, k, p, sh, e;
        logic [23:0] ma, mb, mx, my;
        logic [127:0] n, rem, half, q;
        logic        inx;
        sa = x_in[31];
        sb = y_in[31] ^ op_sub;
        ea = int'(x_in[30:23]);
        eb = int'(y_in[30:23]);
        if ((ea == 255 && x_in[22:0] != 23'd0) || (eb == 255 && y_in[22:0] != 23'd0))
            return {NAN_C, 3'b100};
        if (ea == 255 && eb == 255)
            return (sa != sb) ? {NAN_C, 3'b100} : {sa, 8'hFF, 23'd0, 3'b000};
        if (ea == 255) return {sa, 8'hFF, 23'd0, 3'b000};
        if (eb == 255) return {sb, 8'hFF, 23'd0, 3'b000};
        ma = (ea == 0) ? 24'd0 : {1'b1, x_in[22:0]};
        mb = (eb == 0) ? 24'd0 : {1'b1, y_in[22:0]};
        if (ma == 24'd0 && mb == 24'd0) return {sa & sb, 31'd0, 3'b000};
        if (eb > ea || (eb == ea && mb > ma)) begin
            sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
        end else begin
            sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
        end
        d = ex - ey;
        if (my == 24'd0) begin
            n = 128'(mx); k = ex;
        end else if (d <= 40) begin
            n = (128'(mx) << d);
            n = (sx == sy) ? n + 128'(my) : n - 128'(my);
            k = ey;
        end else begin
            n = (128'(mx) << 42);
            n = (sx == sy) ? n + 128'd1 : n - 128'd1;
            k = ex - 42;
        end
        if (n == 128'd0) return {32'd0, 3'b000};
        p = 0;
        for (int i = 0; i < 128; i++) if (n[i]) p = i;
        e = p + k - 23;
        if (e <= 0) return {sx, 31'd0, 3'b001};
        inx = 1'b0;
        if (p > 23) begin
            sh   = p - 23;
            q    = n >> sh;
            rem  = n & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
            inx  = (rem != 128'd0);
            if (rem > half || (rem == half && q[0])) q = q + 128'd1;
        end else begin
            q = n << (23 - p);
        end
        if (q[24]) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {sx, 8'hFF, 23'd0, 3'b011};
        return {sx, 8'(e), q[22:0], 2'b00, inx};
    endfunction

    // Monitor: latency, stability under back-pressure, and in-order result comparison
    always @(negedge clk) begin
        logic [34:0] e;
        if (rst) begin
            pend_acc = -1;
            prev_ov  = 1'b0;
        end else begin
            if (out_valid) begin
                if (pend_acc >= 0) begin
                    chk("latency", 64'(cyc - pend_acc), 64'd6);
                    pend_acc = -1;
                end
                if (prev_ov) chk("stable_out", 64'({s, flag_invalido, flag_overflow, flag_inexato}), 64'(prev_sf));
                chk("in_ready_while_valid", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'(s), 64'hDEAD_DEAD_DEAD_DEAD);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", 64'({s, flag_invalido, flag_overflow, flag_inexato}), 64'(e));
                    end
                    prev_ov = 1'b0;
                end else begin
                    prev_ov = 1'b1;
                    prev_sf = {s, flag_invalido, flag_overflow, flag_inexato};
                end
            end else begin
                prev_ov = 1'b0;
            end
            if (in_valid && in_ready) begin
                pend_acc = cyc;
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enviar(input logic [31:0] aa, input logic [31:0] bb, input logic ss);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            a = aa; b = bb; sub = ss; in_valid = 1'b1;
            exp_q.push_back(ref_model(aa, bb, ss));
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic esperar();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("result_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] rnd_op(input logic [7:0] eref);
        logic [31:0] v;
        int          k, e;
        v = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) begin
            v[30:23] = 8'd0;
            if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
        end else if (k == 1) begin
            v[30:23] = 8'hFF;
            if ($urandom_range(0, 2) != 0) v[22:0] = 23'd0;
        end else if (k <= 11) begin
            e = int'(eref) + $urandom_range(0, 60) - 30;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            v[30:23] = 8'(e);
        end else begin
            v[30:23] = eref;
        end
        return v;
    endfunction

    logic [31:0] dir_a [14] = '{32'h3F800000, 32'h3F800000, 32'hC0400000, 32'h3F800000,
                                32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001,
                                32'h80000000, 32'h00000001, 32'h00C00000, 32'h3F800000,
                                32'hFF800000, 32'h40490FDB};
    logic [31:0] dir_b [14] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h33800000,
                                32'h33800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
                                32'h00000000, 32'h00000001, 32'h00800000, 32'h00800000,
                                32'h3F800000, 32'hC0490FDA};
    logic        dir_s [14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int n;
        int base;
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_s", 64'(s), 64'd0);
        chk("reset_flags", 64'({flag_invalido, flag_overflow, flag_inexato}), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            enviar(dir_a[i], dir_b[i], dir_s[i]);
            esperar();
        end

        // Back-pressure: result held, then released
        out_ready = 1'b0;
        enviar(32'h40400000, 32'h3F800000, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        esperar();

        // Continuous in_valid: accepts must be spaced exactly 7 cycles
        base = acc_cyc.size();
        a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            exp_q.push_back(ref_model(32'h3F800000, 32'h40000000, 1'b0));
            tick();
        end
        in_valid = 1'b0;
        esperar();
        chk("b2b_count", 64'(acc_cyc.size() - base), 64'd3);
        if (acc_cyc.size() - base == 3) begin
            chk("b2b_gap1", 64'(acc_cyc[base+1] - acc_cyc[base]), 64'd7);
            chk("b2b_gap2", 64'(acc_cyc[base+2] - acc_cyc[base+1]), 64'd7);
        end

        // Reset while in SOMA aborts the operation
        enviar(32'h41200000, 32'h40A00000, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_s", 64'(s), 64'd0);
        repeat (8) tick();
        chk("abort_no_output", 64'(out_valid), 64'd0);
        enviar(32'h41200000, 32'h40A00000, 1'b1);
        esperar();

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra[30:23] = 8'(253 + $urandom_range(0, 1));
            rb = ($urandom_range(0, 15) == 0) ? ra : rnd_op(ra[30:23]);
            enviar(ra, rb, 1'($urandom_range(0, 1)));
            esperar();
        end

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
